// File: rtl/unified_mem_arbiter_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter.
// Contents:
//   - default sizes: backing memory bytes, address width, fetch and data
//     transfer lengths
//   - arbiter state encoding, requester (owner) encoding
//   - status codes; a caller maps an address error onto STAT_ADR
//   - helper used by the grant logic to range-check a transfer
package unified_mem_arbiter_pkg;

  localparam int unsigned MEM_BYTES_DEF   = 1024;
  localparam int unsigned MEM_AW_DEF      = 10;
  localparam int unsigned FETCH_BYTES_DEF = 10;
  localparam int unsigned DATA_BYTES_DEF  = 8;
  // Wide enough to hold the longest transfer length and the byte index
  localparam int unsigned LEN_W           = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    F_RD = 3'd1,
    D_RD = 3'd2,
    D_WR = 3'd3,
    DONE = 3'd4
  } state_e;

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    STAT_AOK = 2'd0,
    STAT_HLT = 2'd1,
    STAT_ADR = 2'd2,
    STAT_INS = 2'd3
  } stat_e;

  // A transfer of len bytes starting at addr is illegal when its last byte
  // would fall past the end of memory. Subtracting len from the memory size
  // (instead of adding it to addr) keeps huge addresses from wrapping around.
  function automatic logic addrOutOfRange(input logic [63:0] addr,
                                          input logic [63:0] memBytes,
                                          input logic [63:0] len);
    return addr > (memBytes - len);
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_byte_seq.sv
// Byte sequencer for the unified memory arbiter.
// Ports:
//   clk_i    clock
//   reset_i  synchronous active-high reset, clears the index
//   start_i  restart the sequence at byte 0 on the next cycle
//   len_i    transfer length in bytes
//   k_o      index of the byte being transferred this cycle
//   last_o   high while k_o addresses the final byte of the transfer
module unified_mem_arbiter_byte_seq
  import unified_mem_arbiter_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  output logic [LEN_W-1:0] k_o,
  output logic             last_o
);

  logic [LEN_W-1:0] k_q, k_d;

  // The index saturates at len-1 instead of wrapping, so it simply parks
  // on the final byte once a transfer has finished.
  always_comb begin
    last_o = (k_q >= (len_i - LEN_W'(1)));
    k_d    = k_q;
    if (start_i) begin
      k_d = '0;
    end else if (!last_o) begin
      k_d = k_q + LEN_W'(1);
    end
  end

  // Index register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      k_q <= '0;
    end else begin
      k_q <= k_d;
    end
  end

  assign k_o = k_q;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one byte-wide unified memory between the fetch stage
// (multi-byte instruction windows) and the memory stage (word reads/writes).
// Ports:
//   clk_i, reset_i              clock, synchronous active-high reset
//   f_req_i, f_addr_i           fetch request and start byte address
//   f_rdata_o                   fetched bytes, first byte in the MSBs
//   f_done_o, f_err_o           fetch complete pulse, address error flag
//   d_req_i, d_we_i, d_addr_i   data request, write select, start address
//   d_wdata_i                   write word, MSB byte goes to d_addr_i
//   d_rdata_o                   read word, first byte in the MSBs
//   d_done_o, d_err_o           data complete pulse, address error flag
//   mem_addr_o, mem_wdata_o     backing memory address and write byte
//   mem_we_o, mem_rdata_i       backing memory write enable, read byte
//   busy_o                      high whenever a transaction is in progress
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = MEM_BYTES_DEF,
  parameter int unsigned MEM_AW      = MEM_AW_DEF,
  parameter int unsigned FETCH_BYTES = FETCH_BYTES_DEF,
  parameter int unsigned DATA_BYTES  = DATA_BYTES_DEF
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     f_req_i,
  input  logic [63:0]              f_addr_i,
  output logic [8*FETCH_BYTES-1:0] f_rdata_o,
  output logic                     f_done_o,
  output logic                     f_err_o,
  input  logic                     d_req_i,
  input  logic                     d_we_i,
  input  logic [63:0]              d_addr_i,
  input  logic [8*DATA_BYTES-1:0]  d_wdata_i,
  output logic [8*DATA_BYTES-1:0]  d_rdata_o,
  output logic                     d_done_o,
  output logic                     d_err_o,
  output logic [MEM_AW-1:0]        mem_addr_o,
  output logic [7:0]               mem_wdata_o,
  output logic                     mem_we_o,
  input  logic [7:0]               mem_rdata_i,
  output logic                     busy_o
);

  localparam int unsigned FW = 8 * FETCH_BYTES;
  localparam int unsigned DW = 8 * DATA_BYTES;
  localparam logic [LEN_W-1:0] FETCH_LEN = LEN_W'(FETCH_BYTES);
  localparam logic [LEN_W-1:0] DATA_LEN  = LEN_W'(DATA_BYTES);

  state_e            state_q, state_d;
  owner_e            lastGrant_q, owner_q;
  logic              err_q;
  logic [MEM_AW-1:0] baseAddr_q;
  logic [DW-1:0]     wdata_q;
  logic [FW-1:0]     asm_q;
  logic [FW-1:0]     fRdata_q;
  logic [DW-1:0]     dRdata_q;

  logic              grantAny, grantData, reqErr, seqStart, seqLast;
  owner_e            grantOwner;
  logic [63:0]       reqAddr;
  logic [LEN_W-1:0]  reqLen, curLen, seqK;

  // Grant decision for the IDLE cycle. With both requesters asking, the one
  // not served last wins; last grant resets to fetch so data goes first.
  always_comb begin
    grantAny   = f_req_i || d_req_i;
    grantData  = d_req_i && (!f_req_i || (lastGrant_q == OWNER_FETCH));
    grantOwner = grantData ? OWNER_DATA : OWNER_FETCH;
    reqAddr    = grantData ? d_addr_i : f_addr_i;
    reqLen     = grantData ? DATA_LEN : FETCH_LEN;
    reqErr     = addrOutOfRange(reqAddr, 64'(MEM_BYTES), 64'(reqLen));
    seqStart   = (state_q == IDLE) && grantAny;
    curLen     = (owner_q == OWNER_FETCH) ? FETCH_LEN : DATA_LEN;
  end

  unified_mem_arbiter_byte_seq u_seq (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .start_i (seqStart),
    .len_i   (curLen),
    .k_o     (seqK),
    .last_o  (seqLast)
  );

  // State register; a reset in the middle of a transfer simply abandons it
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. An out-of-range request skips the memory entirely and
  // reports its error in DONE on the very next cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grantAny) begin
          if (reqErr) begin
            state_d = DONE;
          end else if (!grantData) begin
            state_d = F_RD;
          end else if (d_we_i) begin
            state_d = D_WR;
          end else begin
            state_d = D_RD;
          end
        end
      end
      F_RD, D_RD, D_WR: begin
        if (seqLast) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs. The memory bus is held at zero outside transfers, and the write
  // enable is cut by reset so an aborted write stops on the reset cycle.
  always_comb begin
    busy_o      = (state_q != IDLE);
    f_done_o    = (state_q == DONE) && (owner_q == OWNER_FETCH);
    d_done_o    = (state_q == DONE) && (owner_q == OWNER_DATA);
    f_err_o     = f_done_o && err_q;
    d_err_o     = d_done_o && err_q;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = 1'b0;
    if ((state_q == F_RD) || (state_q == D_RD) || (state_q == D_WR)) begin
      mem_addr_o = baseAddr_q + MEM_AW'(seqK);
    end
    if (state_q == D_WR) begin
      mem_wdata_o = wdata_q[DW-1 -: 8];
      mem_we_o    = !reset_i;
    end
  end

  // Datapath. Read bytes shift into the LSB end so the first byte ends up in
  // the MSBs; the final byte is merged straight into the result register so
  // the result is already valid during DONE. The write word shifts left so
  // its top byte is always the one going out.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lastGrant_q <= OWNER_FETCH;
      owner_q     <= OWNER_FETCH;
      err_q       <= 1'b0;
      baseAddr_q  <= '0;
      wdata_q     <= '0;
      asm_q       <= '0;
      fRdata_q    <= '0;
      dRdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grantAny) begin
            lastGrant_q <= grantOwner;
            owner_q     <= grantOwner;
            err_q       <= reqErr;
            baseAddr_q  <= reqAddr[MEM_AW-1:0];
            wdata_q     <= d_wdata_i;
            asm_q       <= '0;
            if (reqErr && grantData) begin
              dRdata_q <= '0;
            end else if (reqErr) begin
              fRdata_q <= '0;
            end
          end
        end
        F_RD: begin
          asm_q <= {asm_q[FW-9:0], mem_rdata_i};
          if (seqLast) begin
            fRdata_q <= {asm_q[FW-9:0], mem_rdata_i};
          end
        end
        D_RD: begin
          asm_q <= {asm_q[FW-9:0], mem_rdata_i};
          if (seqLast) begin
            dRdata_q <= {asm_q[DW-9:0], mem_rdata_i};
          end
        end
        D_WR: begin
          wdata_q <= {wdata_q[DW-9:0], 8'h00};
        end
        default: begin
        end
      endcase
    end
  end

  assign f_rdata_o = fRdata_q;
  assign d_rdata_o = dRdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed testbench for unified_mem_arbiter. Models the backing byte memory
// (combinational read, posedge write) and exercises fetch, data read/write,
// arbitration, range errors, reset mid-transfer and requests dropped early.
// Cycle 0 of every transaction is the IDLE cycle in which the request is seen.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        fReq;
  logic [63:0] fAddr;
  logic [79:0] fRdata;
  logic        fDone, fErr;
  logic        dReq, dWe;
  logic [63:0] dAddr, dWdata, dRdata;
  logic        dDone, dErr;
  logic [9:0]  memAddr;
  logic [7:0]  memWdata, memRdata;
  logic        memWe;
  logic        busy;

  logic [7:0]  mem [0:1023];
  logic        preWe = 1'b0;
  logic [9:0]  preAddr = '0;
  logic [7:0]  preData = '0;

  int checkCount = 0;
  int passCount  = 0;
  int weCount    = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .f_req_i     (fReq),
    .f_addr_i    (fAddr),
    .f_rdata_o   (fRdata),
    .f_done_o    (fDone),
    .f_err_o     (fErr),
    .d_req_i     (dReq),
    .d_we_i      (dWe),
    .d_addr_i    (dAddr),
    .d_wdata_i   (dWdata),
    .d_rdata_o   (dRdata),
    .d_done_o    (dDone),
    .d_err_o     (dErr),
    .mem_addr_o  (memAddr),
    .mem_wdata_o (memWdata),
    .mem_we_o    (memWe),
    .mem_rdata_i (memRdata),
    .busy_o      (busy)
  );

  // Backing memory; the bench preloads it through the same write process
  always @(posedge clk) begin
    if (preWe) begin
      mem[preAddr] <= preData;
    end else if (memWe) begin
      mem[memAddr] <= memWdata;
    end
    if (memWe) begin
      weCount <= weCount + 1;
    end
  end

  assign memRdata = mem[memAddr];

  // Hard time limit so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, summary not reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic loadByte(input int addr, input logic [7:0] data);
    preAddr = 10'(addr);
    preData = data;
    preWe   = 1'b1;
    @(posedge clk); #1;
    preWe   = 1'b0;
  endtask

  task automatic applyReset(input int n);
    reset = 1'b1;
    fReq  = 1'b0;
    dReq  = 1'b0;
    dWe   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Move to the start of a fresh cycle in which the DUT is idle
  task automatic idleStart();
    @(posedge clk); #1;
    for (int i = 0; i < 50 && busy; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Count cycles from the current cycle (cycle 0) until the chosen done
  // pulse is seen; -1 when the budget runs out. Returns at the negedge of
  // the done cycle so the caller can sample the results.
  task automatic runUntilDone(input bit isFetch, input int budget, output int doneCyc);
    doneCyc = -1;
    for (int c = 0; c <= budget; c++) begin
      @(negedge clk);
      if (isFetch ? fDone : dDone) begin
        doneCyc = c;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; fReq = 1'b0; dReq = 1'b0; dWe = 1'b0;
    fAddr = '0; dAddr = '0; dWdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkCount++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passCount++;
    checkCount++;
    if (memWe !== 1'b0) $display("[TB] FAIL reset_mem_we: got %b want 0", memWe); else passCount++;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkCount++;
    if (fRdata !== 80'h0) $display("[TB] FAIL reset_f_rdata: got %h want 0", fRdata); else passCount++;
    checkCount++;
    if (dRdata !== 64'h0) $display("[TB] FAIL reset_d_rdata: got %h want 0", dRdata); else passCount++;
    checkCount++;
    if ({fDone, fErr, dDone, dErr} !== 4'b0000)
      $display("[TB] FAIL reset_done_err: got %b want 0000", {fDone, fErr, dDone, dErr});
    else passCount++;
    checkCount++;
    if (memAddr !== 10'd0) $display("[TB] FAIL reset_mem_addr: got %0d want 0", memAddr); else passCount++;
  endtask

  task automatic test_fetch();
    int cyc;
    idleStart();
    fReq = 1'b1; fAddr = 64'd4;
    runUntilDone(1'b1, 30, cyc);
    fReq = 1'b0;
    checkCount++;
    if (cyc !== 11) $display("[TB] FAIL fetch_latency: got %0d want 11", cyc); else passCount++;
    checkCount++;
    if (fErr !== 1'b0) $display("[TB] FAIL fetch_err: got %b want 0", fErr); else passCount++;
    checkCount++;
    if (fRdata !== 80'h30F2_0000_0000_0000_0002)
      $display("[TB] FAIL fetch_rdata: got %h want 30f20000000000000002", fRdata);
    else passCount++;
    checkCount++;
    if (dDone !== 1'b0) $display("[TB] FAIL fetch_no_d_done: got %b want 0", dDone); else passCount++;
  endtask

  task automatic test_write_read();
    int cyc;
    idleStart();
    dReq = 1'b1; dWe = 1'b1; dAddr = 64'd100; dWdata = 64'h0102_0304_0506_0708;
    runUntilDone(1'b0, 30, cyc);
    dReq = 1'b0; dWe = 1'b0;
    checkCount++;
    if (cyc !== 9) $display("[TB] FAIL write_latency: got %0d want 9", cyc); else passCount++;
    checkCount++;
    if (dErr !== 1'b0) $display("[TB] FAIL write_err: got %b want 0", dErr); else passCount++;
    for (int i = 0; i < 8; i++) begin
      checkCount++;
      if (mem[100 + i] !== 8'(i + 1))
        $display("[TB] FAIL write_byte_%0d: got %h want %h", i, mem[100 + i], 8'(i + 1));
      else passCount++;
    end
    idleStart();
    dReq = 1'b1; dWe = 1'b0; dAddr = 64'd100;
    runUntilDone(1'b0, 30, cyc);
    dReq = 1'b0;
    checkCount++;
    if (cyc !== 9) $display("[TB] FAIL read_latency: got %0d want 9", cyc); else passCount++;
    checkCount++;
    if (dRdata !== 64'h0102_0304_0506_0708)
      $display("[TB] FAIL read_rdata: got %h want 0102030405060708", dRdata);
    else passCount++;
  endtask

  task automatic test_arbitration();
    int dCyc, fCyc, n;
    int gotCyc[4];
    int gotWho[4];
    int expCyc[4] = '{9, 21, 31, 43};
    int expWho[4] = '{0, 1, 0, 1};
    applyReset(2);
    idleStart();
    fReq = 1'b1; fAddr = 64'd4; dReq = 1'b1; dWe = 1'b0; dAddr = 64'd100;
    dCyc = -1; fCyc = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dDone && dCyc < 0) begin dCyc = c; dReq = 1'b0; end
      if (fDone && fCyc < 0) begin fCyc = c; fReq = 1'b0; end
      if (dCyc >= 0 && fCyc >= 0) break;
      @(posedge clk); #1;
    end
    fReq = 1'b0; dReq = 1'b0;
    checkCount++;
    if (dCyc !== 9) $display("[TB] FAIL arb_data_first: got %0d want 9", dCyc); else passCount++;
    checkCount++;
    if (fCyc !== 21) $display("[TB] FAIL arb_fetch_second: got %0d want 21", fCyc); else passCount++;
    checkCount++;
    if (dRdata !== 64'h0102_0304_0506_0708)
      $display("[TB] FAIL arb_d_rdata: got %h want 0102030405060708", dRdata);
    else passCount++;
    checkCount++;
    if (fRdata !== 80'h30F2_0000_0000_0000_0002)
      $display("[TB] FAIL arb_f_rdata: got %h want 30f20000000000000002", fRdata);
    else passCount++;

    // Both held continuously: grants must alternate, data first
    idleStart();
    fReq = 1'b1; dReq = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) begin gotCyc[i] = -1; gotWho[i] = -1; end
    for (int c = 0; c < 70 && n < 4; c++) begin
      @(negedge clk);
      if (dDone || fDone) begin
        gotCyc[n] = c;
        gotWho[n] = fDone ? 1 : 0;
        n++;
      end
      if (n < 4) begin
        @(posedge clk); #1;
      end
    end
    fReq = 1'b0; dReq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkCount++;
      if (gotWho[i] !== expWho[i])
        $display("[TB] FAIL alt_owner_%0d: got %0d want %0d (0=data 1=fetch)", i, gotWho[i], expWho[i]);
      else passCount++;
      checkCount++;
      if (gotCyc[i] !== expCyc[i])
        $display("[TB] FAIL alt_cycle_%0d: got %0d want %0d", i, gotCyc[i], expCyc[i]);
      else passCount++;
    end
  endtask

  task automatic test_range_error();
    int cyc, w0;
    idleStart();
    w0 = weCount;
    dReq = 1'b1; dWe = 1'b0; dAddr = 64'd1020;
    runUntilDone(1'b0, 20, cyc);
    dReq = 1'b0;
    checkCount++;
    if (cyc !== 1) $display("[TB] FAIL err_d_latency: got %0d want 1", cyc); else passCount++;
    checkCount++;
    if (dErr !== 1'b1) $display("[TB] FAIL err_d_flag: got %b want 1", dErr); else passCount++;
    checkCount++;
    if (dRdata !== 64'h0) $display("[TB] FAIL err_d_rdata: got %h want 0", dRdata); else passCount++;

    idleStart();
    fReq = 1'b1; fAddr = 64'd1014;
    runUntilDone(1'b1, 30, cyc);
    fReq = 1'b0;
    checkCount++;
    if (cyc !== 11) $display("[TB] FAIL edge_fetch_latency: got %0d want 11", cyc); else passCount++;
    checkCount++;
    if (fErr !== 1'b0) $display("[TB] FAIL edge_fetch_err: got %b want 0", fErr); else passCount++;
    checkCount++;
    if (fRdata !== 80'hE0E1_E2E3_E4E5_E6E7_E8E9)
      $display("[TB] FAIL edge_fetch_rdata: got %h want e0e1e2e3e4e5e6e7e8e9", fRdata);
    else passCount++;

    idleStart();
    fReq = 1'b1; fAddr = 64'd1015;
    runUntilDone(1'b1, 30, cyc);
    fReq = 1'b0;
    checkCount++;
    if (cyc !== 1) $display("[TB] FAIL err_f_latency: got %0d want 1", cyc); else passCount++;
    checkCount++;
    if (fErr !== 1'b1) $display("[TB] FAIL err_f_flag: got %b want 1", fErr); else passCount++;
    checkCount++;
    if (fRdata !== 80'h0) $display("[TB] FAIL err_f_rdata: got %h want 0", fRdata); else passCount++;

    idleStart();
    dReq = 1'b1; dWe = 1'b0; dAddr = 64'd1016;
    runUntilDone(1'b0, 30, cyc);
    dReq = 1'b0;
    checkCount++;
    if (cyc !== 9) $display("[TB] FAIL edge_data_latency: got %0d want 9", cyc); else passCount++;
    checkCount++;
    if (dRdata !== 64'hE2E3_E4E5_E6E7_E8E9 || dErr !== 1'b0)
      $display("[TB] FAIL edge_data_rdata: got %h err %b want e2e3e4e5e6e7e8e9 err 0", dRdata, dErr);
    else passCount++;

    idleStart();
    dReq = 1'b1; dWe = 1'b1; dAddr = 64'hFFFF_FFFF_FFFF_FFFF; dWdata = 64'h1122_3344_5566_7788;
    runUntilDone(1'b0, 20, cyc);
    dReq = 1'b0; dWe = 1'b0;
    checkCount++;
    if (cyc !== 1 || dErr !== 1'b1)
      $display("[TB] FAIL err_huge_addr: got cycle %0d err %b want cycle 1 err 1", cyc, dErr);
    else passCount++;
    checkCount++;
    if (weCount !== w0) $display("[TB] FAIL err_no_write: got %0d writes want 0", weCount - w0); else passCount++;
  endtask

  task automatic test_reset_mid_write();
    bit sawDone;
    for (int i = 0; i < 8; i++) loadByte(100 + i, 8'h55);
    idleStart();
    dReq = 1'b1; dWe = 1'b1; dAddr = 64'd100; dWdata = 64'hAAAA_AAAA_AAAA_AAAA;
    sawDone = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c == 4) begin reset = 1'b1; dReq = 1'b0; dWe = 1'b0; end
      if (c == 5) reset = 1'b0;
      @(negedge clk);
      if (dDone) sawDone = 1'b1;
      if (c == 4) begin
        checkCount++;
        if (memWe !== 1'b0) $display("[TB] FAIL rst_we_gated: got %b want 0", memWe); else passCount++;
      end
      if (c == 5) begin
        checkCount++;
        if (busy !== 1'b0) $display("[TB] FAIL rst_busy_c5: got %b want 0", busy); else passCount++;
      end
      @(posedge clk); #1;
    end
    checkCount++;
    if (sawDone !== 1'b0) $display("[TB] FAIL rst_no_done: got %b want 0", sawDone); else passCount++;
    for (int i = 0; i < 8; i++) begin
      checkCount++;
      if (mem[100 + i] !== ((i < 3) ? 8'hAA : 8'h55))
        $display("[TB] FAIL rst_byte_%0d: got %h want %h", i, mem[100 + i], (i < 3) ? 8'hAA : 8'h55);
      else passCount++;
    end
  endtask

  task automatic test_drop_mid();
    int fCyc, dCyc;
    logic [9:0] addr13;
    idleStart();
    fReq = 1'b1; fAddr = 64'd4;
    fCyc = -1; dCyc = -1; addr13 = '0;
    for (int c = 0; c < 40; c++) begin
      if (c == 1) begin dReq = 1'b1; dWe = 1'b0; dAddr = 64'd100; end
      if (c == 3) fReq = 1'b0;
      @(negedge clk);
      if (fDone && fCyc < 0) fCyc = c;
      if (c == 13) addr13 = memAddr;
      if (dDone) begin
        dCyc = c;
        dReq = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    dReq = 1'b0;
    checkCount++;
    if (fCyc !== 11) $display("[TB] FAIL drop_f_done: got %0d want 11", fCyc); else passCount++;
    checkCount++;
    if (fRdata !== 80'h30F2_0000_0000_0000_0002)
      $display("[TB] FAIL drop_f_rdata: got %h want 30f20000000000000002", fRdata);
    else passCount++;
    checkCount++;
    if (addr13 !== 10'd100) $display("[TB] FAIL drop_d_grant: got mem_addr %0d want 100", addr13); else passCount++;
    checkCount++;
    if (dCyc !== 21) $display("[TB] FAIL drop_d_done: got %0d want 21", dCyc); else passCount++;
    checkCount++;
    if (dRdata !== 64'hAAAA_AA55_5555_5555)
      $display("[TB] FAIL drop_d_rdata: got %h want aaaaaa5555555555", dRdata);
    else passCount++;
  endtask

  // Test sequence
  initial begin
    reset = 1'b1;
    fReq = 1'b0; dReq = 1'b0; dWe = 1'b0;
    fAddr = '0; dAddr = '0; dWdata = '0;
    test_reset();
    loadByte(4, 8'h30);
    loadByte(5, 8'hF2);
    for (int i = 6; i < 13; i++) loadByte(i, 8'h00);
    loadByte(13, 8'h02);
    for (int i = 0; i < 10; i++) loadByte(1014 + i, 8'(8'hE0 + i));
    test_fetch();
    test_write_read();
    test_arbitration();
    test_range_error();
    test_reset_mid_write();
    test_drop_mid();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
